// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and counter-width helper
// for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd1,
        S_WAIT   = 3'd2,
        S_STABLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 36000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_LOSS_W        = 8;

    // Bits needed to hold 0..limit-1, never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level into the local clock.
module cdc_sync_bit (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE" *) logic r_sync;

    // Metastability-settling chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/recovery sequencer: pulses the PLL reset, qualifies lock with a
// timeout and bounded retries, and holds the output-domain reset until RUN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int LOSS_W        = DEF_LOSS_W
) (
    input  logic                                  i_refclk,
    input  logic                                  i_rst,
    input  logic                                  i_pll_locked,
    input  logic                                  i_relock_req,
    input  logic                                  i_clr_fault,
    output logic                                  o_pll_rst,
    output logic                                  o_dom_rst,
    output logic                                  o_ready,
    output logic                                  o_fault,
    output logic [2:0]                            o_state,
    output logic [cnt_width(MAX_RETRIES+1)-1:0]   o_retry_cnt,
    output logic [LOSS_W-1:0]                     o_loss_cnt
);

    localparam int RW     = cnt_width(MAX_RETRIES + 1);
    localparam int RST_W  = cnt_width(RST_CYCLES);
    localparam int TMO_W  = cnt_width(LOCK_TIMEOUT);
    localparam int STAB_W = cnt_width(STABLE_CYCLES);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [RW-1:0]     RETRY_ONE = RW'(1);
    localparam logic [LOSS_W-1:0] LOSS_MAX  = {LOSS_W{1'b1}};
    localparam logic [LOSS_W-1:0] LOSS_ONE  = LOSS_W'(1);

    state_e              r_state;
    logic [RST_W-1:0]    r_rst_cnt;
    logic [TMO_W-1:0]    r_tmo;
    logic [STAB_W-1:0]   r_stab;
    logic [RW-1:0]       r_retry;
    logic [LOSS_W-1:0]   r_loss;
    logic                r_pll_rst;
    logic                r_dom_rst;
    logic                r_ready;
    logic                r_fault;

    state_e              w_state_nxt;
    logic [RST_W-1:0]    w_rst_cnt_nxt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic [STAB_W-1:0]   w_stab_nxt;
    logic [RW-1:0]       w_retry_nxt;
    logic [LOSS_W-1:0]   w_loss_nxt;
    logic                w_pll_rst_nxt;
    logic                w_dom_rst_nxt;
    logic                w_ready_nxt;
    logic                w_fault_nxt;
    logic                w_lock_s;
    logic                w_timeout;
    logic                w_retry_done;

    cdc_sync_bit u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lock_s)
    );

    assign w_timeout    = (r_tmo == TMO_LAST);
    assign w_retry_done = (r_retry == RETRY_MAX);

    // Next-state and counter update; the tmo timer spans WAIT and STABLE together.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_tmo_nxt     = r_tmo;
        w_stab_nxt    = r_stab;
        w_retry_nxt   = r_retry;
        w_loss_nxt    = r_loss;
        case (r_state)
            S_RESET: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt   = S_WAIT;
                    w_rst_cnt_nxt = '0;
                    w_tmo_nxt     = '0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RST_ONE;
                end
            end
            S_WAIT: begin
                if (w_timeout) begin
                    w_stab_nxt = '0;
                    if (w_retry_done) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt   = S_RESET;
                        w_rst_cnt_nxt = '0;
                        w_retry_nxt   = r_retry + RETRY_ONE;
                    end
                end else begin
                    w_tmo_nxt = r_tmo + TMO_ONE;
                    if (w_lock_s) begin
                        w_state_nxt = S_STABLE;
                        w_stab_nxt  = '0;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_STABLE: begin
                // Qualifying on the timeout cycle still wins.
                if (w_lock_s && (r_stab == STAB_LAST)) begin
                    w_state_nxt = S_RUN;
                    w_stab_nxt  = '0;
                    w_retry_nxt = '0;
                end else if (w_timeout) begin
                    w_stab_nxt = '0;
                    if (w_retry_done) begin
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt   = S_RESET;
                        w_rst_cnt_nxt = '0;
                        w_retry_nxt   = r_retry + RETRY_ONE;
                    end
                end else begin
                    w_tmo_nxt = r_tmo + TMO_ONE;
                    if (w_lock_s) begin
                        w_stab_nxt = r_stab + STAB_ONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_stab_nxt  = '0;
                    end
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt   = S_RESET;
                    w_rst_cnt_nxt = '0;
                    if (r_loss != LOSS_MAX) begin
                        w_loss_nxt = r_loss + LOSS_ONE;
                    end else begin
                        w_loss_nxt = r_loss;
                    end
                end else if (i_relock_req) begin
                    w_state_nxt   = S_RESET;
                    w_rst_cnt_nxt = '0;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FAULT: begin
                if (i_clr_fault) begin
                    w_state_nxt   = S_RESET;
                    w_rst_cnt_nxt = '0;
                    w_retry_nxt   = '0;
                end else begin
                    w_state_nxt = S_FAULT;
                end
            end
            default: begin
                w_state_nxt   = S_RESET;
                w_rst_cnt_nxt = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs flip on the state-entry edge.
    always_comb begin
        w_pll_rst_nxt = 1'b1;
        w_dom_rst_nxt = 1'b1;
        w_ready_nxt   = 1'b0;
        w_fault_nxt   = 1'b0;
        case (w_state_nxt)
            S_WAIT, S_STABLE: begin
                w_pll_rst_nxt = 1'b0;
            end
            S_RUN: begin
                w_pll_rst_nxt = 1'b0;
                w_dom_rst_nxt = 1'b0;
                w_ready_nxt   = 1'b1;
            end
            S_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_pll_rst_nxt = 1'b1;
            end
        endcase
    end

    // State, timers, status counters and registered outputs.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state   <= S_RESET;
            r_rst_cnt <= '0;
            r_tmo     <= '0;
            r_stab    <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_pll_rst <= 1'b1;
            r_dom_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_tmo     <= w_tmo_nxt;
            r_stab    <= w_stab_nxt;
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_dom_rst <= w_dom_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_dom_rst   = r_dom_rst;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;
    assign o_state     = r_state;
    assign o_retry_cnt = r_retry;
    assign o_loss_cnt  = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a small PLL model (programmable
// lock delay, chatter pattern, or manual drive).
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_pll_locked;
    logic       i_relock_req = 1'b0;
    logic       i_clr_fault = 1'b0;
    logic       o_pll_rst;
    logic       o_dom_rst;
    logic       o_ready;
    logic       o_fault;
    logic [2:0] o_state;
    logic [1:0] o_retry_cnt;
    logic [7:0] o_loss_cnt;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   pll_mode = 0;      // 0 delayed lock, 1 chatter 5/3, 2 manual
    int   lock_delay = 20;
    int   pll_cnt = 0;
    logic mdl_lock = 1'b0;
    logic man_lock = 1'b0;

    assign i_pll_locked = (pll_mode == 2) ? man_lock : mdl_lock;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (64),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .LOSS_W        (8)
    ) dut (
        .i_refclk     (clk),
        .i_rst        (i_rst),
        .i_pll_locked (i_pll_locked),
        .i_relock_req (i_relock_req),
        .i_clr_fault  (i_clr_fault),
        .o_pll_rst    (o_pll_rst),
        .o_dom_rst    (o_dom_rst),
        .o_ready      (o_ready),
        .o_fault      (o_fault),
        .o_state      (o_state),
        .o_retry_cnt  (o_retry_cnt),
        .o_loss_cnt   (o_loss_cnt)
    );

    always #5 clk = ~clk;

    // PLL model: lock is lost while its reset is high, then follows the mode.
    always @(posedge clk) begin
        #1;
        if (o_pll_rst !== 1'b0) begin
            pll_cnt  = 0;
            mdl_lock = 1'b0;
        end else if (pll_mode == 1) begin
            mdl_lock = ((pll_cnt % 8) < 5);
            pll_cnt++;
        end else begin
            if (pll_cnt >= lock_delay) mdl_lock = 1'b1;
            pll_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        i_relock_req = 1'b0;
        i_clr_fault  = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_until_ready(input int budget, output int n);
        n = 0;
        while (o_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        int         k;
        logic       relock;
        logic [2:0] st;
        logic       prst;
        logic       drst;
        logic       rdy;
        logic       flt;
        logic [1:0] rty;
        logic [7:0] loss;
    } vec_t;

    vec_t vt[10];
    int   n;
    int   rises;
    int   hi;
    logic prev;
    logic saw_ready;
    logic saw_stable;
    int   exp_loss;

    initial begin
        // Bring-up with lock 20 cycles after pll_rst falls (falls at k=4).
        vt[0] = '{0,  1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[1] = '{3,  1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[2] = '{4,  1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[3] = '{10, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[4] = '{11, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[5] = '{26, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[6] = '{27, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[7] = '{34, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        vt[8] = '{35, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
        vt[9] = '{36, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};

        pll_mode   = 0;
        lock_delay = 20;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            while (cyc < vt[i].k) tick();
            check($sformatf("v%0d_state", i), 32'(o_state), 32'(vt[i].st));
            check($sformatf("v%0d_pll_rst", i), 32'(o_pll_rst), 32'(vt[i].prst));
            check($sformatf("v%0d_dom_rst", i), 32'(o_dom_rst), 32'(vt[i].drst));
            check($sformatf("v%0d_ready", i), 32'(o_ready), 32'(vt[i].rdy));
            check($sformatf("v%0d_fault", i), 32'(o_fault), 32'(vt[i].flt));
            check($sformatf("v%0d_retry", i), 32'(o_retry_cnt), 32'(vt[i].rty));
            check($sformatf("v%0d_loss", i), 32'(o_loss_cnt), 32'(vt[i].loss));
            i_relock_req = vt[i].relock;
        end

        // Loss of lock in RUN for 3 cycles.
        pll_mode = 2;
        man_lock = 1'b0;
        tick();
        tick();
        check("loss_still_ready", 32'(o_ready), 32'd1);
        tick();
        check("loss_ready", 32'(o_ready), 32'd0);
        check("loss_state", 32'(o_state), 32'd1);
        check("loss_dom_rst", 32'(o_dom_rst), 32'd1);
        check("loss_cnt1", 32'(o_loss_cnt), 32'd1);
        pll_mode = 0;
        run_until_ready(100, n);
        check("relock_cycles", 32'(n), 32'd35);

        // relock_req in RUN with lock held.
        i_relock_req = 1'b1;
        tick();
        check("req_state", 32'(o_state), 32'd1);
        check("req_pll_rst", 32'(o_pll_rst), 32'd1);
        check("req_loss", 32'(o_loss_cnt), 32'd1);
        run_until_ready(100, n);
        check("req_cycles", 32'(n), 32'd35);

        // relock_req on the same cycle the synced lock drops.
        pll_mode = 2;
        man_lock = 1'b0;
        tick();
        tick();
        check("reqloss_run", 32'(o_state), 32'd4);
        i_relock_req = 1'b1;
        tick();
        check("reqloss_state", 32'(o_state), 32'd1);
        check("reqloss_loss", 32'(o_loss_cnt), 32'd2);
        pll_mode = 0;
        run_until_ready(100, n);
        check("reqloss_cycles", 32'(n), 32'd35);

        // 300 one-cycle losses: counter saturates at 255.
        pll_mode = 2;
        man_lock = 1'b1;
        exp_loss = 2;
        for (int i = 0; i < 300; i++) begin
            man_lock = 1'b0;
            tick();
            man_lock = 1'b1;
            tick();
            tick();
            if (exp_loss < 255) exp_loss++;
            check("sat_loss", 32'(o_loss_cnt), 32'(exp_loss));
            run_until_ready(60, n);
            check("sat_cycles", 32'(n), 32'd13);
        end
        check("sat_final", 32'(o_loss_cnt), 32'd255);

        // rst pulse while in STABLE.
        i_relock_req = 1'b1;
        tick();
        repeat (7) tick();
        check("rst6_pre_state", 32'(o_state), 32'd3);
        i_rst = 1'b1;
        tick();
        check("rst6_state", 32'(o_state), 32'd1);
        check("rst6_pll_rst", 32'(o_pll_rst), 32'd1);
        check("rst6_dom_rst", 32'(o_dom_rst), 32'd1);
        check("rst6_ready", 32'(o_ready), 32'd0);
        check("rst6_fault", 32'(o_fault), 32'd0);
        check("rst6_retry", 32'(o_retry_cnt), 32'd0);
        check("rst6_loss", 32'(o_loss_cnt), 32'd0);
        i_rst = 1'b0;
        run_until_ready(60, n);
        check("rst6_cycles", 32'(n), 32'd13);

        // Never lock: three attempts then FAULT.
        pll_mode   = 0;
        lock_delay = 1000000;
        do_reset();
        rises = 0;
        hi    = (o_pll_rst === 1'b1) ? 1 : 0;
        prev  = o_pll_rst;
        for (int k = 1; k <= 204; k++) begin
            tick();
            if (prev === 1'b0 && o_pll_rst === 1'b1) rises++;
            if (k < 204 && o_pll_rst === 1'b1) hi++;
            prev = o_pll_rst;
            if (k == 70)  check("nl_retry1", 32'(o_retry_cnt), 32'd1);
            if (k == 140) check("nl_retry2", 32'(o_retry_cnt), 32'd2);
            if (k == 203) check("nl_pre_fault", 32'(o_fault), 32'd0);
        end
        check("nl_rises", 32'(rises), 32'd3);
        check("nl_hi_cycles", 32'(hi), 32'd12);
        check("nl_fault", 32'(o_fault), 32'd1);
        check("nl_state", 32'(o_state), 32'd5);
        check("nl_pll_rst", 32'(o_pll_rst), 32'd1);
        check("nl_dom_rst", 32'(o_dom_rst), 32'd1);
        check("nl_retry", 32'(o_retry_cnt), 32'd2);
        i_relock_req = 1'b1;
        tick();
        repeat (3) tick();
        check("fault_hold", 32'(o_state), 32'd5);
        i_clr_fault = 1'b1;
        tick();
        check("clr_state", 32'(o_state), 32'd1);
        check("clr_fault", 32'(o_fault), 32'd0);
        check("clr_retry", 32'(o_retry_cnt), 32'd0);
        check("clr_pll_rst", 32'(o_pll_rst), 32'd1);
        repeat (3) tick();
        check("clr_pulse_hi", 32'(o_pll_rst), 32'd1);
        tick();
        check("clr_pulse_lo", 32'(o_pll_rst), 32'd0);
        check("clr_wait", 32'(o_state), 32'd2);

        // Chattering lock: never qualifies, times out once.
        pll_mode = 1;
        do_reset();
        saw_ready  = 1'b0;
        saw_stable = 1'b0;
        for (int k = 1; k <= 68; k++) begin
            tick();
            if (o_ready === 1'b1) saw_ready = 1'b1;
            if (o_state === 3'd3) saw_stable = 1'b1;
            if (k == 67) check("ch_retry0", 32'(o_retry_cnt), 32'd0);
        end
        check("ch_never_ready", 32'(saw_ready), 32'd0);
        check("ch_saw_stable", 32'(saw_stable), 32'd1);
        check("ch_state", 32'(o_state), 32'd1);
        check("ch_retry1", 32'(o_retry_cnt), 32'd1);
        check("ch_pll_rst", 32'(o_pll_rst), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
